// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the nibble-serial adder.
//   SLICE_W   : width of the shared adder slice
//   state_t   : sequencer states
//   slice_of  : signed-overflow equation from operand and result MSBs
//   sat_pos / sat_neg : clamp values used when ADD_SAT_EN is defined
//                       (the returned value is truncated by the caller)
package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Overflow happens only when both operands share a sign and the
    // result's sign differs from it.
    function automatic logic slice_of(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Largest positive w-bit two's complement value: 0 followed by all 1s.
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative w-bit two's complement value: 1 followed by all 0s.
    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/nibble_add_seq_add4_slice.sv
// Combinational 4-bit adder slice shared by every step of the sequencer.
//   a4, b4 : slice operands
//   ci     : carry in
//   s4     : slice sum
//   co     : carry out
module add4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co
);

    assign {co, s4} = {1'b0, a4} + {1'b0, b4} + {4'b0000, ci};

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder that walks 4-bit slices LSB first through one
// shared add4_slice, chaining the carry. Results appear only on completion.
//   clk, rst        : clock, synchronous active-high reset
//   start           : request an add; accepted only while busy=0
//   a, b, cin       : operands and carry in, captured with start
//   busy            : operation in progress
//   done            : one-cycle pulse when sum/cout/of update
//   sum, cout, of   : registered result, unsigned carry, signed overflow
// Optional macro ADD_SAT_EN: clamp sum to the signed limit on overflow.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q;
    logic [WIDTH-1:0]     a_q, b_q, acc_q, acc_nxt;
    logic                 c_q;
    logic [SLICE_W-1:0]   a4, b4, s4;
    logic                 co;
    logic                 last;
    logic                 ovf;

    // Slice select and accumulator merge use constant indices only.
    always_comb begin
        a4      = '0;
        b4      = '0;
        acc_nxt = acc_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_q == KW'(i)) begin
                a4 = a_q[i*SLICE_W +: SLICE_W];
                b4 = b_q[i*SLICE_W +: SLICE_W];
                acc_nxt[i*SLICE_W +: SLICE_W] = s4;
            end
        end
    end

    add4_slice u_slice (
        .a4 (a4),
        .b4 (b4),
        .ci (c_q),
        .s4 (s4),
        .co (co)
    );

    assign last = (k_q == KW'(NSLICE - 1));
    assign ovf  = slice_of(a_q[WIDTH-1], b_q[WIDTH-1], acc_nxt[WIDTH-1]);
    assign busy = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            acc_q <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            of    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        c_q <= cin;
                        k_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    c_q   <= co;
                    k_q   <= k_q + KW'(1);
                    if (last) begin
`ifdef ADD_SAT_EN
                        if (ovf)
                            sum <= a_q[WIDTH-1] ? WIDTH'(sat_neg(WIDTH))
                                                : WIDTH'(sat_pos(WIDTH));
                        else
                            sum <= acc_nxt;
`else
                        sum <= acc_nxt;
`endif
                        cout <= co;
                        of   <= ovf;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (WIDTH=16): directed cases plus
// randomized operands against an integer-arithmetic reference model.
module tb_nibble_add_seq;

    localparam int WIDTH  = 16;
    localparam int NSLICE = 4;

    logic             clk = 1'b0;
    logic             rst, start, cin;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout, of;
    logic [WIDTH-1:0] sum;

    int checks = 0;
    int errors = 0;

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .of    (of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {of, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
        int          sx, sy, s;
        logic [31:0] u;
        logic        ofl;
        logic [15:0] r;
        sx  = $signed(x);
        sy  = $signed(y);
        s   = sx + sy + int'(c);
        u   = 32'(x) + 32'(y) + 32'(c);
        ofl = (s > 32767) || (s < -32768);
        r   = u[15:0];
`ifdef ADD_SAT_EN
        if (s > 32767)       r = 16'h7FFF;
        else if (s < -32768) r = 16'h8000;
`endif
        return {ofl, u[16], r};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
        logic [17:0] e;
        int          n;
        e = model(x, y, c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk({tag, "_lat"}, n, NSLICE);
        chk({tag, "_sum"}, 32'(sum), 32'(e[15:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[16]));
        chk({tag, "_of"}, 32'(of), 32'(e[17]));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_low"}, 32'(done), 0);
        chk({tag, "_held"}, 32'(sum), 32'(e[15:0]));
    endtask

    initial begin
        int last_done, pulses, seen;
        logic [15:0] rx, ry;
        logic        rc;

        // Reset with start asserted: nothing must start.
        rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_of", 32'(of), 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_idle", 32'(busy), 0);

        run_op("basic", 16'h00FF, 16'h0001, 1'b0);
        run_op("cin", 16'h000F, 16'h0000, 1'b1);
        run_op("negov", 16'hFFFF, 16'h8000, 1'b0);
        run_op("posov", 16'h7FFF, 16'h4000, 1'b0);
        run_op("max_cin", 16'hFFFF, 16'hFFFF, 1'b1);

        // start held high: done every 5 edges, mid-run operand change ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        last_done = -1; pulses = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) a = 16'h1234;
            if (cyc == 4) a = 16'h0001;
            if (done) begin
                pulses++;
                chk("hs_sum", 32'(sum), 32'h0002);
                if (last_done >= 0) chk("hs_period", cyc - last_done, 5);
                else                chk("hs_first", cyc, NSLICE + 1);
                last_done = cyc;
            end
        end
        start = 1'b0;
        chk("hs_pulses", pulses, 3);
        repeat (6) @(posedge clk);

        // Abort mid-run with reset.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sum", 32'(sum), 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", seen, 0);
        run_op("abort_fresh", 16'h1111, 16'h2222, 1'b0);

        // Randomized operands.
        for (int i = 0; i < 20; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op("rand", rx, ry, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
Multi-cycle sequencer that adds two WIDTH-bit operands by passing 4-bit slices, LSB first, through one shared 4-bit adder slice. It chains the carry between slices and reports carry-out and signed overflow for the full word. It is used wherever a wide add must reuse the existing 4-bit overflow-aware adder instead of building a full-width adder.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, derived local constant; number of slice cycles

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new add; sampled only when busy=0
a  input  WIDTH  operand A (two's complement or unsigned), sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry into slice 0, sampled with start
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse: sum/cout/of just updated
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  unsigned carry out of the top slice
of  output  1  signed overflow of the full-width add

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at an edge: state=IDLE, slice counter=0, busy=0, done=0, sum=0, cout=0, of=0, internal operand/carry registers=0.
- FSM states: IDLE and RUN. done is a registered flag, not a separate state.
- IDLE: at an edge with start=1, latch a, b, cin. Set counter k=0, busy=1, go to RUN. done is cleared at every edge where it is not being set.
- RUN: at each edge, apply slice k: a[4k+3:4k], b[4k+3:4k], and the running carry (cin for k=0) to the adder slice. Store the 4-bit result into the internal accumulator at slice k, store the carry for the next slice, then k=k+1.
- On the edge that processes slice NSLICE-1:
  - sum = accumulator (all slices)
  - cout = carry out of the top slice
  - of = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed on the unsaturated sum
  - done=1, busy=0, state=IDLE
- Latency: start sampled at edge E0; done=1 after edge E_NSLICE (4 edges for WIDTH=16); done low again after E_NSLICE+1 unless a new completion occurs.
- Back-to-back: start=1 during the done cycle is accepted, because busy=0. Throughput is one result per NSLICE+1 edges.
- start=1 while busy=1 is ignored with no queuing. Changes to a, b or cin during RUN have no effect.
- sum/cout/of change only on a completion edge or reset. There are no partial results on outputs.
- WIDTH=4: a single RUN cycle.
- Reset mid-RUN aborts the operation: no done pulse, and all outputs return to 0.

Optional Feature:
Macro ADD_SAT_EN.
- Defined: on a completion edge with of=1, sum is clamped.
  - Operands positive (a[MSB]=0): 0 followed by all 1s.
  - Operands negative: 1 followed by all 0s.
  - of and cout still report the unsaturated values.
- Undefined: sum wraps modulo 2^WIDTH, and no clamp logic is present.

Decomposition:
- Package add_seq_pkg:
  - SLICE_W=4
  - typedef enum for states {IDLE, RUN}
  - function slice_of(a_msb, b_msb, s_msb) for the overflow equation
  - saturation constant helpers
- Sub-module add4_slice: combinational 4-bit add with inputs a4, b4, ci and outputs s4, co. It is instantiated once. The sequencer owns all registers.

Test Plan:
All scenarios use WIDTH=16.
- Reset: rst=1 for 2 edges with start=1 -> busy=0, done=0, sum=0x0000, cout=0, of=0, and no operation starts.
- Basic add: a=0x00FF, b=0x0001, cin=0, start pulse at E0 -> busy=1 through E3. After E4: done=1 for exactly one cycle, sum=0x0100, cout=0, of=0. Then a=0x000F, b=0x0000, cin=1 -> sum=0x0010.
- Negative overflow: a=0xFFFF, b=0x8000, cin=0 -> sum=0x7FFF, cout=1, of=1. With ADD_SAT_EN: sum=0x8000, cout=1, of=1.
- Positive overflow: a=0x7FFF, b=0x4000, cin=0 -> sum=0xBFFF, cout=0, of=1. With ADD_SAT_EN: sum=0x7FFF.
- Handshake: start held high continuously with a=0x0001, b=0x0001.
  - Second start during RUN is ignored.
  - start in the done cycle is accepted, so done pulses every 5 edges.
  - Changing a to 0x1234 during RUN still gives sum=0x0002.
- Abort: start with a=0x1111, b=0x2222, then rst=1 at E2 -> busy=0, done never pulses, sum=0x0000. A fresh start afterwards gives sum=0x3333 after 4 edges.
